// File: rtl/siu_l2_trk_pkg.sv
// ---------------------------------------------------------------------------
// siu_l2_trk_pkg
// Shared definitions for the SIU -> L2 tag request tracker:
//   - default values for the tracker parameters
//   - per-channel header FSM state encoding
//   - bit positions inside each channel's 3-bit error field
// Optional feature macro used by the tracker files: SIU_L2_TRK_STATS_EN
// ---------------------------------------------------------------------------
package siu_l2_trk_pkg;

    localparam int NUM_L2T_DEF = 8;
    localparam int REQ_W_DEF   = 32;
    localparam int GAP_CYC_DEF = 3;
    localparam int CNT_W_DEF   = 4;

    // Error field layout: {underflow, overflow, proto}
    localparam int ERR_W = 3;
    localparam int PROTO = 0;
    localparam int OVF   = 1;
    localparam int UNF   = 2;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_GAP  = 2'd3
    } trk_state_e;

endpackage

// File: rtl/siu_l2_trk_chan.sv
// ---------------------------------------------------------------------------
// siu_l2_trk_chan
// One L2 tag channel of the request tracker: captures the two-word request
// header, sequences the dummy gap, counts outstanding IQ entries and keeps
// sticky protocol/overflow/underflow flags.
// Ports:
//   clk, rst_i        clock and synchronous active-high reset
//   req_vld_i, req_i  request valid and request word
//   iq_dequeue_i      IQ entry consumed by the L2 tag
//   err_clr_i         clears the sticky error flags
//   hdr_vld_o, hdr_o  header-captured pulse and held header {word1, word0}
//   outstanding_o     IQ entries not yet dequeued
//   err_sticky_o      {underflow, overflow, proto}
//   err_pulse_o       pulse when any error flag is written
//   (SIU_L2_TRK_STATS_EN) wib_dequeue_i, pkt_cnt_o, wib_cnt_o
// ---------------------------------------------------------------------------
module siu_l2_trk_chan
    import siu_l2_trk_pkg::*;
#(
    parameter int REQ_W   = REQ_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 req_vld_i,
    input  logic [REQ_W-1:0]     req_i,
    input  logic                 iq_dequeue_i,
    input  logic                 err_clr_i,
`ifdef SIU_L2_TRK_STATS_EN
    input  logic                 wib_dequeue_i,
    output logic [STAT_W-1:0]    pkt_cnt_o,
    output logic [STAT_W-1:0]    wib_cnt_o,
`endif
    output logic                 hdr_vld_o,
    output logic [2*REQ_W-1:0]   hdr_o,
    output logic [CNT_W-1:0]     outstanding_o,
    output logic [ERR_W-1:0]     err_sticky_o,
    output logic                 err_pulse_o
);

    localparam logic [2:0]       GAP_LD  = 3'(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trk_state_e         state_q, state_d;
    logic [2:0]         gap_cnt_q, gap_cnt_d;
    logic [REQ_W-1:0]   word0_q;
    logic [2*REQ_W-1:0] hdr_q;
    logic               hdr_vld_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d, err_new;
    logic               err_pulse_q;
    logic               cap0, cap1, proto_evt;
    logic               inc, dec;

    // State register plus everything captured on the FSM's strobes
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            word0_q     <= '0;
            hdr_q       <= '0;
            hdr_vld_q   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            if (cap0) word0_q <= req_i;
            // word0 is staged so hdr only changes on a complete capture
            if (cap1) hdr_q <= {req_i, word0_q};
            hdr_vld_q   <= cap1;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_pulse_q <= |err_new;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: if (req_vld_i) state_d = ST_HDR0;
            ST_HDR0: state_d = ST_HDR1;
            ST_HDR1: begin
                if (GAP_CYC == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LD;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 3'd1;
                if (gap_cnt_q <= 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: capture strobes and the protocol-violation event
    always_comb begin
        cap0      = (state_q == ST_HDR0);
        cap1      = (state_q == ST_HDR1);
        proto_evt = req_vld_i && (state_q != ST_IDLE);
    end

    // Outstanding counter; a simultaneous increment and dequeue cancel
    always_comb begin
        inc     = hdr_vld_q;
        dec     = iq_dequeue_i;
        cnt_d   = cnt_q;
        err_new = '0;
        err_new[PROTO] = proto_evt;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) err_new[OVF] = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) err_new[UNF] = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
        // A new event overrides a coincident clear
        err_d = (err_q & ~{ERR_W{err_clr_i}}) | err_new;
    end

`ifdef SIU_L2_TRK_STATS_EN
    logic [STAT_W-1:0] pkt_cnt_q, wib_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
            wib_cnt_q <= '0;
        end else begin
            if (hdr_vld_q)     pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (wib_dequeue_i) wib_cnt_q <= wib_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign wib_cnt_o = wib_cnt_q;
`endif

    assign hdr_vld_o     = hdr_vld_q;
    assign hdr_o         = hdr_q;
    assign outstanding_o = cnt_q;
    assign err_sticky_o  = err_q;
    assign err_pulse_o   = err_pulse_q;

endmodule

// File: rtl/siu_l2_req_tracker.sv
// ---------------------------------------------------------------------------
// siu_l2_req_tracker
// Tracks SIU -> L2 tag request headers on NUM_L2T independent channels.
// Channel n uses slice n of every packed bus.
// Ports:
//   iol2clk, rst     clock and synchronous active-high reset
//   req_vld, req     per-channel request valid / request word (REQ_W each)
//   iq_dequeue       per-channel IQ dequeue
//   wib_dequeue      per-channel WIB dequeue (only counted with stats)
//   err_clr          clears all sticky error flags
//   hdr_vld, hdr     header-captured pulse / header (2*REQ_W each)
//   outstanding      outstanding IQ entries (CNT_W each)
//   err_sticky       {underflow, overflow, proto} per channel
//   err_pulse        per-channel error pulse
// Optional macro SIU_L2_TRK_STATS_EN adds pkt_cnt and wib_cnt (16 bits each).
// ---------------------------------------------------------------------------
module siu_l2_req_tracker
    import siu_l2_trk_pkg::*;
#(
    parameter int NUM_L2T = NUM_L2T_DEF,
    parameter int REQ_W   = REQ_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       iol2clk,
    input  logic                       rst,
    input  logic [NUM_L2T-1:0]         req_vld,
    input  logic [NUM_L2T*REQ_W-1:0]   req,
    input  logic [NUM_L2T-1:0]         iq_dequeue,
    input  logic [NUM_L2T-1:0]         wib_dequeue,
    input  logic                       err_clr,
`ifdef SIU_L2_TRK_STATS_EN
    output logic [NUM_L2T*STAT_W-1:0]  pkt_cnt,
    output logic [NUM_L2T*STAT_W-1:0]  wib_cnt,
`endif
    output logic [NUM_L2T-1:0]         hdr_vld,
    output logic [NUM_L2T*2*REQ_W-1:0] hdr,
    output logic [NUM_L2T*CNT_W-1:0]   outstanding,
    output logic [NUM_L2T*ERR_W-1:0]   err_sticky,
    output logic [NUM_L2T-1:0]         err_pulse
);

`ifndef SIU_L2_TRK_STATS_EN
    // WIB dequeues only feed the statistics counters
    logic wib_unused;
    assign wib_unused = ^wib_dequeue;
`endif

    generate
        for (genvar gi = 0; gi < NUM_L2T; gi++) begin : g_chan
            siu_l2_trk_chan #(
                .REQ_W   (REQ_W),
                .GAP_CYC (GAP_CYC),
                .CNT_W   (CNT_W)
            ) u_chan (
                .clk           (iol2clk),
                .rst_i         (rst),
                .req_vld_i     (req_vld[gi]),
                .req_i         (req[gi*REQ_W +: REQ_W]),
                .iq_dequeue_i  (iq_dequeue[gi]),
                .err_clr_i     (err_clr),
`ifdef SIU_L2_TRK_STATS_EN
                .wib_dequeue_i (wib_dequeue[gi]),
                .pkt_cnt_o     (pkt_cnt[gi*STAT_W +: STAT_W]),
                .wib_cnt_o     (wib_cnt[gi*STAT_W +: STAT_W]),
`endif
                .hdr_vld_o     (hdr_vld[gi]),
                .hdr_o         (hdr[gi*2*REQ_W +: 2*REQ_W]),
                .outstanding_o (outstanding[gi*CNT_W +: CNT_W]),
                .err_sticky_o  (err_sticky[gi*ERR_W +: ERR_W]),
                .err_pulse_o   (err_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_siu_l2_req_tracker.sv
// ---------------------------------------------------------------------------
// tb_siu_l2_req_tracker
// Self-checking bench: a table of ch0 vectors, directed multi-cycle
// sequences, and randomized traffic on all channels compared with a
// timeline model of the tracker. A second instance uses CNT_W=2.
// ---------------------------------------------------------------------------
module tb_siu_l2_req_tracker;

    localparam int N   = 8;
    localparam int RW  = 32;
    localparam int GAP = 3;
    localparam int CW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_vld, iq_dequeue, wib_dequeue;
    logic [N*RW-1:0]  req;
    logic             err_clr;
    logic [N-1:0]     hdr_vld, err_pulse;
    logic [N*2*RW-1:0] hdr;
    logic [N*CW-1:0]  outstanding;
    logic [N*3-1:0]   err_sticky;

    // Second instance: 2 channels, 2-bit counters
    logic [1:0]       d2_req_vld, d2_iq, d2_wib;
    logic [2*RW-1:0]  d2_req;
    logic             d2_clr;
    logic [1:0]       d2_hdr_vld, d2_pulse;
    logic [2*2*RW-1:0] d2_hdr;
    logic [3:0]       d2_out;
    logic [5:0]       d2_err;

`ifdef SIU_L2_TRK_STATS_EN
    logic [N*16-1:0]  pkt_cnt, wib_cnt;
    logic [2*16-1:0]  d2_pkt_cnt, d2_wib_cnt;
`endif

    always #5 clk = ~clk;

    siu_l2_req_tracker #(.NUM_L2T(N), .REQ_W(RW), .GAP_CYC(GAP), .CNT_W(CW)) dut (
        .iol2clk     (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req         (req),
        .iq_dequeue  (iq_dequeue),
        .wib_dequeue (wib_dequeue),
        .err_clr     (err_clr),
`ifdef SIU_L2_TRK_STATS_EN
        .pkt_cnt     (pkt_cnt),
        .wib_cnt     (wib_cnt),
`endif
        .hdr_vld     (hdr_vld),
        .hdr         (hdr),
        .outstanding (outstanding),
        .err_sticky  (err_sticky),
        .err_pulse   (err_pulse)
    );

    siu_l2_req_tracker #(.NUM_L2T(2), .REQ_W(RW), .GAP_CYC(GAP), .CNT_W(2)) dut2 (
        .iol2clk     (clk),
        .rst         (rst),
        .req_vld     (d2_req_vld),
        .req         (d2_req),
        .iq_dequeue  (d2_iq),
        .wib_dequeue (d2_wib),
        .err_clr     (d2_clr),
`ifdef SIU_L2_TRK_STATS_EN
        .pkt_cnt     (d2_pkt_cnt),
        .wib_cnt     (d2_wib_cnt),
`endif
        .hdr_vld     (d2_hdr_vld),
        .hdr         (d2_hdr),
        .outstanding (d2_out),
        .err_sticky  (d2_err),
        .err_pulse   (d2_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_vld = '0; req = '0; iq_dequeue = '0; wib_dequeue = '0; err_clr = 1'b0;
        d2_req_vld = '0; d2_req = '0; d2_iq = '0; d2_wib = '0; d2_clr = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model (timeline of each packet) -----------
    int          cyc;
    int          m_start [N];
    logic [31:0] m_w0    [N];
    logic [63:0] m_hdr   [N];
    logic        m_vld   [N];
    int          m_cnt   [N];
    logic [2:0]  m_err   [N];
    logic        m_pulse [N];

    // Advance the model by one cycle using the inputs about to be sampled.
    // A packet accepted at cycle s occupies s+1..s+2+GAP; the channel takes
    // a new packet from cycle s+3+GAP on.
    task automatic model_step();
        for (int ch = 0; ch < N; ch++) begin
            logic p, nv, inc, dec, ovf, unf;
            if (rst) begin
                m_start[ch] = -100; m_w0[ch] = '0; m_hdr[ch] = '0; m_vld[ch] = 1'b0;
                m_cnt[ch] = 0; m_err[ch] = '0; m_pulse[ch] = 1'b0;
            end else begin
                p = 1'b0; nv = 1'b0;
                if (cyc >= m_start[ch] + 3 + GAP) begin
                    if (req_vld[ch]) m_start[ch] = cyc;
                end else begin
                    p = req_vld[ch];
                    if (cyc == m_start[ch] + 1) m_w0[ch] = req[ch*RW +: RW];
                    if (cyc == m_start[ch] + 2) begin
                        m_hdr[ch] = {req[ch*RW +: RW], m_w0[ch]};
                        nv = 1'b1;
                    end
                end
                inc = m_vld[ch];
                dec = iq_dequeue[ch];
                ovf = inc && !dec && (m_cnt[ch] == (1 << CW) - 1);
                unf = dec && !inc && (m_cnt[ch] == 0);
                if (inc && !dec && !ovf) m_cnt[ch] = m_cnt[ch] + 1;
                if (dec && !inc && !unf) m_cnt[ch] = m_cnt[ch] - 1;
                m_err[ch]   = (err_clr ? 3'b000 : m_err[ch]) | {unf, ovf, p};
                m_pulse[ch] = unf | ovf | p;
                m_vld[ch]   = nv;
            end
        end
        cyc++;
    endtask

    // ---------------- table of ch0 vectors ---------------------------------
    typedef struct {
        logic        vld;
        logic [31:0] rq;
        logic        iq;
        logic        clr;
        logic        e_vld;
        logic [63:0] e_hdr;
        logic [3:0]  e_out;
        logic [2:0]  e_err;
        logic        e_pulse;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] h1, h2;
        int          pulses;
        h1 = 64'hBBBB0002_AAAA0001;
        h2 = 64'h33334444_11112222;
        tbl[0]  = '{1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'hAAAA0001, 1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 32'hBBBB0002, 1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, h1,    4'd0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, h1,    4'd1, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, h1,    4'd0, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0,        1'b0, 1'b0, 1'b0, h1,    4'd0, 3'd0, 1'b0};
        tbl[7]  = '{1'b0, 32'h11112222, 1'b0, 1'b0, 1'b0, h1,    4'd0, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 32'h33334444, 1'b0, 1'b0, 1'b0, h1,    4'd0, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, h2,    4'd0, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, h2,    4'd1, 3'd0, 1'b0};

        // ---- reset state ----
        reset_dut();
        check("reset main", {hdr_vld, outstanding, err_sticky, err_pulse, (|hdr)}, '0);
        check("reset dut2", {d2_hdr_vld, d2_out, d2_err, d2_pulse, (|d2_hdr)}, '0);

        // ---- table: two back-to-back packets on ch0 ----
        for (int i = 0; i < 11; i++) begin
            req_vld[0]      = tbl[i].vld;
            req[0 +: RW]    = tbl[i].rq;
            iq_dequeue[0]   = tbl[i].iq;
            err_clr         = tbl[i].clr;
            check($sformatf("tbl row%0d", i),
                  {hdr_vld[0], hdr[0 +: 64], outstanding[0 +: CW], err_sticky[0 +: 3], err_pulse[0]},
                  {tbl[i].e_vld, tbl[i].e_hdr, tbl[i].e_out, tbl[i].e_err, tbl[i].e_pulse});
            tick();
        end
        clear_inputs();

        // ---- proto error on ch3: second req_vld inside HDR1 ----
        reset_dut();
        req_vld[3] = 1'b1; tick();
        req_vld[3] = 1'b0; tick();
        req_vld[3] = 1'b1; tick();
        req_vld[3] = 1'b0;
        check("proto sticky", err_sticky[9 +: 3], 3'b001);
        check("proto pulse", err_pulse[3], 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (hdr_vld[3]) pulses++;
            tick();
        end
        check("proto hdr_vld count", pulses, 1);
        check("proto held", {err_sticky[9 +: 3], err_pulse[3]}, 4'b0010);

        // ---- underflow on ch5, clear, clear-vs-event priority ----
        reset_dut();
        iq_dequeue[5] = 1'b1; tick();
        iq_dequeue[5] = 1'b0;
        check("unf set", {err_sticky[15 +: 3], outstanding[20 +: CW], err_pulse[5]}, {3'b100, 4'd0, 1'b1});
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        check("unf cleared", {err_sticky[15 +: 3], err_pulse[5]}, 4'b0000);
        err_clr = 1'b1; iq_dequeue[5] = 1'b1; tick();
        err_clr = 1'b0; iq_dequeue[5] = 1'b0;
        check("event beats clear", err_sticky[15 +: 3], 3'b100);

        // ---- CNT_W=2 overflow on dut2 ch1 ----
        reset_dut();
        for (int p = 0; p < 4; p++) begin
            d2_req_vld[1] = 1'b1; tick();
            d2_req_vld[1] = 1'b0;
            for (int k = 0; k < 7; k++) tick();
        end
        check("ovf count", d2_out[3:2], 2'd3);
        check("ovf sticky", d2_err[5:3], 3'b010);
        d2_clr = 1'b1; tick();
        d2_clr = 1'b0;
        d2_req_vld[1] = 1'b1; tick();
        d2_req_vld[1] = 1'b0; tick(); tick();
        check("ovf5 hdr_vld", d2_hdr_vld[1], 1'b1);
        d2_iq[1] = 1'b1; tick();
        d2_iq[1] = 1'b0;
        check("inc+deq hold", {d2_out[3:2], d2_err[5:3], d2_pulse[1]}, {2'd3, 3'b000, 1'b0});

        // ---- reset during a ch7 capture ----
        reset_dut();
        req_vld[7] = 1'b1; tick();
        req_vld[7] = 1'b0; req[7*RW +: RW] = 32'hDEAD0007; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        check("rst abort", {hdr_vld, outstanding, err_sticky, err_pulse, (|hdr)}, '0);
        req_vld[7] = 1'b1; tick();
        req_vld[7] = 1'b0; tick(); tick();
        check("post-rst accept", hdr_vld[7], 1'b1);
        req = '0;

`ifdef SIU_L2_TRK_STATS_EN
        // ---- statistics counters on ch2 ----
        reset_dut();
        for (int p = 0; p < 5; p++) begin
            req_vld[2] = 1'b1;
            wib_dequeue[2] = (p < 2);
            tick();
            req_vld[2] = 1'b0; wib_dequeue[2] = 1'b0;
            for (int k = 0; k < 7; k++) tick();
        end
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        check("pkt_cnt", pkt_cnt[32 +: 16], 16'd5);
        check("wib_cnt", wib_cnt[32 +: 16], 16'd2);
`endif

        // ---- randomized traffic vs. model ----
        clear_inputs();
        cyc = 0;
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                check($sformatf("rand ch%0d cyc%0d", ch, cyc),
                      {hdr_vld[ch], hdr[ch*64 +: 64], outstanding[ch*CW +: CW], err_sticky[ch*3 +: 3], err_pulse[ch]},
                      {m_vld[ch], m_hdr[ch], 4'(m_cnt[ch]), m_err[ch], m_pulse[ch]});
            end
            rst     = ($urandom_range(0, 299) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            for (int ch = 0; ch < N; ch++) begin
                req_vld[ch]        = ($urandom_range(0, 3) == 0);
                iq_dequeue[ch]     = ($urandom_range(0, 5) == 0);
                wib_dequeue[ch]    = ($urandom_range(0, 1) == 0);
                req[ch*RW +: RW]   = $urandom;
            end
            model_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
